id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

Pipeline register between the Decode (ID) and Execute (EX) stages of the ARM-subset core. It captures the decoded instruction fields and control signals every cycle. It converts an instruction into a bubble when its condition fails or a hazard stalls it, and it supports pipeline freeze and branch flush. Its `cond_pass` input is the single-bit result of the condition-check logic, which evaluates the 4-bit condition code against the NZCV status flags.

## Interface
Parameters:
- `DATA_W`, 32, register/PC data width
- `REG_W`, 4, register index width

Ports (clock and reset first; single clock domain; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `freeze` in 1: hold all outputs (memory stall)
- `flush` in 1: branch taken in EX; squash the ID instruction
- `hazard` in 1: ID hazard detected; insert bubble
- `cond_pass` in 1: condition-check result for the ID instruction
- `valid_in` in 1: ID holds a real instruction
- `pc_in` in DATA_W
- `val_rn_in`, `val_rm_in` in DATA_W
- `imm_in` in 1
- `shift_operand_in` in 12
- `signed_imm_24_in` in 24
- `dest_in`, `src1_in`, `src2_in` in REG_W
- `exe_cmd_in` in 4
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in`, `b_in`, `s_in` in 1
- `status_in` in 4: NZCV snapshot, carry used by the ALU
- Outputs: one `*_out` per input field above, same width, plus `valid_out` (1)
- `bubble_cnt` out 16: count of inserted bubbles (debug)

## Operation
- On each rising `clk`, exactly one action applies, by priority: `rst` > `freeze` > `flush` > bubble > load.
- **rst**: every output, including `bubble_cnt`, becomes 0.
- **freeze**: all outputs hold, including `bubble_cnt`. Pending flush, hazard and bubble conditions are ignored. They are re-evaluated on the first unfrozen cycle, because the EX branch that raised `flush` is itself held.
- **flush**: all fields and `valid_out` become 0. `bubble_cnt` does not change.
- **bubble**: applies when `valid_in` and (`hazard` or not `cond_pass`).
  - Cleared to 0: `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `b_out`, `s_out`, `valid_out`, and `exe_cmd_out` (set to the NOP encoding 4'b0000).
  - All data fields (pc, values, imm, shift, offset, registers, status) load normally, to aid debug.
  - `bubble_cnt` increments by 1 and saturates at 16'hFFFF.
- **load**: all fields are registered from `*_in`, and `valid_out` = `valid_in`.
  - If `valid_in` = 0, the control outputs are forced to 0, as in a bubble, but `bubble_cnt` does not change.
- Condition code 4'b1110 (AL) reaches this block as `cond_pass` = 1. This block never interprets condition codes itself.

## Timing
- Latency is one cycle, input to output. There is no combinational path from any input to any output.
- `freeze` takes effect on the same edge where it is sampled high. It releases one edge after it goes low.
- When `flush` and `hazard` are high in the same cycle, flush wins: the result is an all-zero register and the counter does not change.
- When `rst` is asserted mid-freeze, the reset still clears everything on that edge.
- `bubble_cnt` saturates and never wraps.
- Outputs feed the EX stage directly. The EX stage must not see an asserted control bit for any cycle after a flush or bubble.

## Structure
- Shared package `arm_pkg` holds:
  - the field widths (`SHIFT_W` = 12, `IMM24_W` = 24, `CMD_W` = 4);
  - the `EXE_NOP` = 4'b0000 constant;
  - the `id_ex_ctrl_t` struct {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd};
  - the `id_ex_data_t` struct holding the data fields.
- One sub-module, `pipe_field_reg #(W)`: a W-bit flop with synchronous `clr`, `en`, and reset value 0. It is instantiated once for the control struct and once for the data struct.
- The top level contains the priority decode, the bubble muxing and the saturating counter.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all inputs at 1 → every output, including `bubble_cnt`, reads 0 after the first edge.
- **Normal load:** `valid_in`=1, `cond_pass`=1, `pc_in`=32'h0000_0010, `wb_en_in`=1, `exe_cmd_in`=4'b0001 → the next edge shows identical outputs and `valid_out`=1.
- **Condition fail:** same stimulus with `cond_pass`=0 → the next edge shows `pc_out`=32'h10, `wb_en_out`=0, `exe_cmd_out`=0, `valid_out`=0, and `bubble_cnt` 0→1.
- **Freeze hold:** load `pc_in`=32'h20, then hold `freeze`=1 for 3 cycles while `pc_in`=32'h24 and `flush`=1 → `pc_out` stays 32'h20. On release with `flush` still 1, the next edge zeroes all outputs.
- **Flush vs hazard:** assert `flush`=1 and `hazard`=1 together with `valid_in`=1 → all outputs become 0 and `bubble_cnt` does not change.
- **Saturation:** preload the counter to 16'hFFFE (force), then run 3 hazard cycles → `bubble_cnt` reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM-subset pipeline definitions: field widths, the EX NOP encoding
// and the ID/EX control and data bundles.
package arm_pkg;

  localparam int ARM_DATA_W = 32;
  localparam int ARM_REG_W  = 4;
  localparam int SHIFT_W    = 12;
  localparam int IMM24_W    = 24;
  localparam int CMD_W      = 4;
  localparam int STATUS_W   = 4;
  localparam int CNT_W      = 16;

  localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [ARM_DATA_W-1:0] pc;
    logic [ARM_DATA_W-1:0] val_rn;
    logic [ARM_DATA_W-1:0] val_rm;
    logic                  imm;
    logic [SHIFT_W-1:0]    shift_operand;
    logic [IMM24_W-1:0]    signed_imm_24;
    logic [ARM_REG_W-1:0]  dest;
    logic [ARM_REG_W-1:0]  src1;
    logic [ARM_REG_W-1:0]  src2;
    logic [STATUS_W-1:0]   status;
  } id_ex_data_t;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID->EX boundary bundle: stage controls, decoded fields in, registered fields out.
interface id_ex_stage_reg_if
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);

  logic                freeze;
  logic                flush;
  logic                hazard;
  logic                cond_pass;
  logic                valid_in;
  logic [DATA_W-1:0]   pc_in;
  logic [DATA_W-1:0]   val_rn_in;
  logic [DATA_W-1:0]   val_rm_in;
  logic                imm_in;
  logic [SHIFT_W-1:0]  shift_operand_in;
  logic [IMM24_W-1:0]  signed_imm_24_in;
  logic [REG_W-1:0]    dest_in;
  logic [REG_W-1:0]    src1_in;
  logic [REG_W-1:0]    src2_in;
  logic [CMD_W-1:0]    exe_cmd_in;
  logic                mem_r_en_in;
  logic                mem_w_en_in;
  logic                wb_en_in;
  logic                b_in;
  logic                s_in;
  logic [STATUS_W-1:0] status_in;

  logic                valid_out;
  logic [DATA_W-1:0]   pc_out;
  logic [DATA_W-1:0]   val_rn_out;
  logic [DATA_W-1:0]   val_rm_out;
  logic                imm_out;
  logic [SHIFT_W-1:0]  shift_operand_out;
  logic [IMM24_W-1:0]  signed_imm_24_out;
  logic [REG_W-1:0]    dest_out;
  logic [REG_W-1:0]    src1_out;
  logic [REG_W-1:0]    src2_out;
  logic [CMD_W-1:0]    exe_cmd_out;
  logic                mem_r_en_out;
  logic                mem_w_en_out;
  logic                wb_en_out;
  logic                b_out;
  logic                s_out;
  logic [STATUS_W-1:0] status_out;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output freeze, flush, hazard, cond_pass, valid_in, pc_in, val_rn_in, val_rm_in,
           imm_in, shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in,
           exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, status_in,
    input  valid_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, exe_cmd_out,
           mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, status_out, bubble_cnt
  );

  modport slave (
    input  freeze, flush, hazard, cond_pass, valid_in, pc_in, val_rn_in, val_rm_in,
           imm_in, shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in,
           exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, status_in,
    output valid_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, exe_cmd_out,
           mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, status_out, bubble_cnt
  );

endinterface

// File: rtl/pipe_field_reg.sv
// Generic W-bit pipeline flop: synchronous reset, synchronous clear, load enable.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (rst)       o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_en)  o_q <= i_d;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: freeze/flush/bubble priority decode, control squashing
// and a saturating debug count of inserted bubbles.
module id_ex_stage_reg
  import arm_pkg::*;
#(
  parameter int DATA_W = ARM_DATA_W,
  parameter int REG_W  = ARM_REG_W
) (
  input logic               clk,
  input logic               rst,
  id_ex_stage_reg_if.slave  bus
);

  logic        w_bubble;
  logic        w_advance;
  logic        w_dataClr;
  logic        w_ctrlClr;
  logic        w_cntInc;
  id_ex_ctrl_t w_ctrlD;
  id_ex_ctrl_t w_ctrlQ;
  id_ex_data_t w_dataD;
  id_ex_data_t w_dataQ;

  logic             r_valid;
  logic [CNT_W-1:0] r_bubbleCnt;

  // Freeze blocks every other action; control bits die on flush, bubble or an empty slot.
  always_comb begin
    w_bubble  = bus.valid_in & (bus.hazard | ~bus.cond_pass);
    w_advance = ~bus.freeze;
    w_dataClr = w_advance & bus.flush;
    w_ctrlClr = w_advance & (bus.flush | w_bubble | ~bus.valid_in);
    w_cntInc  = w_advance & ~bus.flush & w_bubble;
  end

  always_comb begin
    w_ctrlD          = '0;
    w_ctrlD.wb_en    = bus.wb_en_in;
    w_ctrlD.mem_r_en = bus.mem_r_en_in;
    w_ctrlD.mem_w_en = bus.mem_w_en_in;
    w_ctrlD.b        = bus.b_in;
    w_ctrlD.s        = bus.s_in;
    w_ctrlD.exe_cmd  = bus.exe_cmd_in;
  end

  always_comb begin
    w_dataD               = '0;
    w_dataD.pc            = ARM_DATA_W'(bus.pc_in);
    w_dataD.val_rn        = ARM_DATA_W'(bus.val_rn_in);
    w_dataD.val_rm        = ARM_DATA_W'(bus.val_rm_in);
    w_dataD.imm           = bus.imm_in;
    w_dataD.shift_operand = bus.shift_operand_in;
    w_dataD.signed_imm_24 = bus.signed_imm_24_in;
    w_dataD.dest          = ARM_REG_W'(bus.dest_in);
    w_dataD.src1          = ARM_REG_W'(bus.src1_in);
    w_dataD.src2          = ARM_REG_W'(bus.src2_in);
    w_dataD.status        = bus.status_in;
  end

  pipe_field_reg #(.W($bits(id_ex_ctrl_t))) u_ctrlReg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_ctrlClr),
    .i_en  (w_advance),
    .i_d   (w_ctrlD),
    .o_q   (w_ctrlQ)
  );

  pipe_field_reg #(.W($bits(id_ex_data_t))) u_dataReg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_dataClr),
    .i_en  (w_advance),
    .i_d   (w_dataD),
    .o_q   (w_dataQ)
  );

  always_ff @(posedge clk) begin
    if (rst)            r_valid <= 1'b0;
    else if (w_advance) r_valid <= bus.valid_in & ~bus.flush & ~w_bubble;
  end

  always_ff @(posedge clk) begin
    if (rst)           r_bubbleCnt <= '0;
    else if (w_cntInc) r_bubbleCnt <= sat_inc(r_bubbleCnt);
  end

  assign bus.valid_out         = r_valid;
  assign bus.bubble_cnt        = r_bubbleCnt;
  assign bus.wb_en_out         = w_ctrlQ.wb_en;
  assign bus.mem_r_en_out      = w_ctrlQ.mem_r_en;
  assign bus.mem_w_en_out      = w_ctrlQ.mem_w_en;
  assign bus.b_out             = w_ctrlQ.b;
  assign bus.s_out             = w_ctrlQ.s;
  assign bus.exe_cmd_out       = w_ctrlQ.exe_cmd;
  assign bus.pc_out            = DATA_W'(w_dataQ.pc);
  assign bus.val_rn_out        = DATA_W'(w_dataQ.val_rn);
  assign bus.val_rm_out        = DATA_W'(w_dataQ.val_rm);
  assign bus.imm_out           = w_dataQ.imm;
  assign bus.shift_operand_out = w_dataQ.shift_operand;
  assign bus.signed_imm_24_out = w_dataQ.signed_imm_24;
  assign bus.dest_out          = REG_W'(w_dataQ.dest);
  assign bus.src1_out          = REG_W'(w_dataQ.src1);
  assign bus.src2_out          = REG_W'(w_dataQ.src2);
  assign bus.status_out        = w_dataQ.status;

endmodule
